// File: rtl/output_buffer_mux_if.sv
// Bus bundle for output_buffer_mux: core-side push port, chip-side output pins and status.
// Define OUTPUT_BUFFER_PARITY_EN to add the data_parity signal.
interface output_buffer_mux_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_valid;
  logic                  core_ready;
  logic                  flush;
  logic                  interface_busy;
  logic                  output_acknowledge;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  output_byte_is_ready;
  logic                  input_acknowledged;
  logic [CNT_W-1:0]      fill_level;
`ifdef OUTPUT_BUFFER_PARITY_EN
  logic                  data_parity;
`endif

  modport master (
    output core_data, core_valid, flush, interface_busy, output_acknowledge,
    input  core_ready, data_out, output_byte_is_ready, input_acknowledged, fill_level
`ifdef OUTPUT_BUFFER_PARITY_EN
    , input data_parity
`endif
  );

  modport slave (
    input  core_data, core_valid, flush, interface_busy, output_acknowledge,
    output core_ready, data_out, output_byte_is_ready, input_acknowledged, fill_level
`ifdef OUTPUT_BUFFER_PARITY_EN
    , output data_parity
`endif
  );
endinterface

// File: rtl/output_buffer_mux.sv
// DEPTH-entry output FIFO presenting the head word on chip pins, popped on ack rising edges.
// Define OUTPUT_BUFFER_PARITY_EN to store and present an even-parity bit per word.
module output_buffer_mux #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  output_buffer_mux_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef OUTPUT_BUFFER_PARITY_EN
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
`else
  localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ack_q;
  logic               busy_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  // Flush wins over both push and pop; ready never looks through a same-cycle pop.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    push  = bus.core_valid && !full && !bus.flush;
    pop   = bus.output_acknowledge && !ack_q && !empty && !bus.flush;
`ifdef OUTPUT_BUFFER_PARITY_EN
    wr_entry = {^bus.core_data, bus.core_data};
`else
    wr_entry = bus.core_data;
`endif
    head = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= bus.output_acknowledge;
      busy_q <= bus.interface_busy;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; contents are only visible while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign bus.core_ready           = !full;
  assign bus.data_out             = head[DATA_WIDTH-1:0];
  assign bus.output_byte_is_ready = !empty;
  assign bus.input_acknowledged   = busy_q;
  assign bus.fill_level           = count;
`ifdef OUTPUT_BUFFER_PARITY_EN
  assign bus.data_parity          = head[DATA_WIDTH];
`endif
endmodule

// File: tb/tb_output_buffer_mux.sv
// Self-checking bench for output_buffer_mux: directed steps then random traffic against a queue model.
module tb_output_buffer_mux;
  localparam int unsigned DW = 8;
  localparam int unsigned DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          ack_prev = 1'b0;
  logic          busy_exp = 1'b0;

  output_buffer_mux_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();
  output_buffer_mux #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] head_exp();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".data_out"}, 32'(bus.data_out), 32'(head_exp()));
    chk({tag, ".ready"}, 32'(bus.output_byte_is_ready), 32'(q.size() != 0));
    chk({tag, ".core_ready"}, 32'(bus.core_ready), 32'(q.size() != DP));
    chk({tag, ".fill"}, 32'(bus.fill_level), 32'(q.size()));
    chk({tag, ".in_ack"}, 32'(bus.input_acknowledged), 32'(busy_exp));
`ifdef OUTPUT_BUFFER_PARITY_EN
    chk({tag, ".parity"}, 32'(bus.data_parity), 32'(^head_exp()));
`endif
  endtask

  // Apply inputs at the falling edge, advance the model at the rising edge, check at the next fall.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic f, input logic a, input logic b);
    logic was_full;
    logic was_empty;
    bus.core_valid         = v;
    bus.core_data          = d;
    bus.flush              = f;
    bus.output_acknowledge = a;
    bus.interface_busy     = b;
    @(posedge clk);
    was_full  = (q.size() == DP);
    was_empty = (q.size() == 0);
    if (f) begin
      q.delete();
    end else begin
      if (a && !ack_prev && !was_empty) void'(q.pop_front());
      if (v && !was_full) q.push_back(d);
    end
    ack_prev = a;
    busy_exp = b;
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    bus.core_valid = 1'b0; bus.core_data = '0; bus.flush = 1'b0;
    bus.output_acknowledge = 1'b0; bus.interface_busy = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    chk_all("in_reset");
    rst = 1'b0;
    step("idle", 0, 8'h00, 0, 0, 0);

    // Single word with latency 1, ack held high pops exactly one
    step("push_a5", 1, 8'hA5, 0, 0, 0);
    chk("head_a5", 32'(bus.data_out), 32'h0000_00A5);
    for (int i = 0; i < 5; i++) step("ack_hold", 0, 8'h00, 0, 1, 0);
    chk("single_pop_fill", 32'(bus.fill_level), 32'd0);
    step("ack_release", 0, 8'h00, 0, 0, 0);

    // Fill, refuse when full, then wrap
    for (int i = 1; i <= 4; i++) step("fill", 1, 8'(i), 0, 0, 0);
    step("full_offer5", 1, 8'h05, 0, 0, 0);
    chk("full_fill4", 32'(bus.fill_level), 32'd4);
    chk("full_ready0", 32'(bus.core_ready), 32'd0);
    step("pop_first", 0, 8'h00, 0, 1, 0);
    step("push5_wrap", 1, 8'h05, 0, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("wrap_order", 32'(bus.data_out), 32'(i));
      step("wrap_pop", 0, 8'h00, 0, 1, 0);
      step("wrap_rel", 0, 8'h00, 0, 0, 0);
    end

    // Simultaneous push and pop edge
    step("sim_a", 1, 8'h20, 0, 0, 0);
    step("sim_b", 1, 8'h21, 0, 0, 0);
    step("sim_both", 1, 8'h10, 0, 1, 0);
    chk("sim_fill2", 32'(bus.fill_level), 32'd2);
    chk("sim_head", 32'(bus.data_out), 32'h21);

    // Flush beats a concurrent push
    step("pre_flush", 1, 8'h30, 0, 0, 0);
    step("flush_push", 1, 8'h77, 1, 0, 0);
    chk("flush_fill0", 32'(bus.fill_level), 32'd0);
    step("post_flush", 0, 8'h00, 0, 0, 0);

    // Busy latency, then asynchronous reset mid-cycle
    step("busy_up", 0, 8'h00, 0, 0, 1);
    chk("busy_ack", 32'(bus.input_acknowledged), 32'd1);
    step("pre_rst_a", 1, 8'h3C, 0, 0, 1);
    step("pre_rst_b", 1, 8'hC3, 0, 0, 1);
    bus.core_valid = 1'b0; bus.interface_busy = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete(); ack_prev = 1'b0; busy_exp = 1'b0;
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("after_rst", 0, 8'h00, 0, 0, 0);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), 8'($urandom),
           ($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_buffer_mux.md
Name: output_buffer_mux

Overview:
Parametrised successor to the single-byte stream-cipher output stage. Buffers keystream/ciphertext words from the cipher core in a DEPTH-entry FIFO and presents the head word on the chip output pins. Each word is held until the chip user acknowledges it. Also drives the chip-level input-acknowledge flag from the interface FSM's busy indication.

Parameters:
DATA_WIDTH, 8, width of each output word.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
core_data  input  DATA_WIDTH  word from cipher core.
core_valid  input  1  core_data valid this cycle.
core_ready  output  1  buffer can accept; equals !full.
flush  input  1  synchronous clear of all buffered words (interface FSM session restart).
interface_busy  input  1  interface FSM not IDLE.
output_acknowledge  input  1  chip pin, already synchronised; user has read data_out.
data_out  output  DATA_WIDTH  head-of-FIFO word; 0 when empty.
output_byte_is_ready  output  1  data_out holds a valid unread word.
input_acknowledged  output  1  registered copy of interface_busy.
fill_level  output  $clog2(DEPTH+1)  number of stored words.

Behaviour:
- Reset (async, rst=1): wr_ptr = 0, rd_ptr = 0, count = 0, ack_q = 0, input_acknowledged = 0. data_out = 0 and output_byte_is_ready = 0 while rst is high and after release until the first push.
- Push: on a clk edge with core_valid && core_ready, write core_data at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
- Pop event: rising edge of output_acknowledge (output_acknowledge && !ack_q) while count != 0. ack_q is output_acknowledge registered. Holding the pin high pops exactly one word. An edge while empty is ignored and not remembered.
- Pop action: rd_ptr advances and wraps.
- data_out = mem[rd_ptr] when count != 0, else 0. output_byte_is_ready = (count != 0).
- Both outputs are combinational from registered state. A word pushed into an empty buffer appears on data_out the cycle after the push edge (latency 1).
- Simultaneous push and pop: both occur and count is unchanged.
  - When full, core_ready = 0, so the push is not accepted even if a pop happens in the same cycle. There is no combinational ready-through-pop path.
  - When empty, a pop edge is ignored and the push proceeds.
- Full: count == DEPTH, core_ready = 0, stored data is untouched.
- flush has priority over push and pop in the same cycle: pointers and count go to 0, and output_byte_is_ready falls the next cycle. ack_q still updates.
- input_acknowledged <= interface_busy every cycle (1-cycle latency).
- fill_level = count.
- Reset mid-operation discards all contents immediately (asynchronous).

Optional Feature:
OUTPUT_BUFFER_PARITY_EN.
- Defined: adds output port data_parity (1 bit) = even parity (XOR reduction) of the stored word, computed at push and stored alongside it in a DEPTH x (DATA_WIDTH+1) memory. data_parity = 0 when empty.
- Not defined: the port and the extra storage bit do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst pulse, no stimulus -> data_out=0, output_byte_is_ready=0, core_ready=1, fill_level=0, input_acknowledged=0.
- Single word: push 0xA5 at cycle N -> cycle N+1 data_out=0xA5, output_byte_is_ready=1. Hold output_acknowledge high 5 cycles -> exactly one pop, output_byte_is_ready=0, fill_level=0.
- Fill and wrap (DEPTH=4): push 0x01..0x04 -> core_ready=0, fill_level=4, 0x05 offered and not accepted. Pop once, then push 0x05 -> pops yield 0x02,0x03,0x04,0x05 in order, so the pointer wrap is exercised.
- Simultaneous: fill_level=2, push 0x10 on the same cycle as an ack rising edge -> fill_level stays 2, head advances to the second word.
- Flush with push: fill_level=3, assert flush together with core_valid and 0x77 -> next cycle fill_level=0, output_byte_is_ready=0, and 0x77 is not stored.
- Busy and mid-reset: interface_busy 0->1 -> input_acknowledged=1 one cycle later. Assert rst asynchronously mid-cycle with fill_level=2 -> outputs go to reset values before the next clk edge.
